// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to its
// programmed quantum of accepted beats, then the grant rotates with no gap.
module weighted_rr_arbiter #(
    parameter  int N  = 4,
    parameter  int WW = 3,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            ack,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          gv_q, gv_d;

    logic [N-1:0]  elig;
    logic [IW-1:0] base;
    logic [IW-1:0] j;
    logic [IW-1:0] win;
    logic [WW-1:0] win_w;
    logic          found;
    logic          load;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req[i] && (weight[i*WW +: WW] != '0);
        end
    end

    // In GRANT the search base is the current owner, so a lone eligible
    // owner wraps around and wins its own regrant.
    always_comb begin
        base  = (state_q == GRANT) ? owner_q : last_q;
        found = 1'b0;
        win   = '0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(base) + k) % N);
            if (elig[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
        win_w = weight[int'(win)*WW +: WW];
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        gv_d     = gv_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = found;
            end
            GRANT: begin
                if (!req[owner_q] || (ack && credit_q == WW'(1))) begin
                    last_d = owner_q;
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        gv_d    = 1'b0;
                    end
                end else if (ack) begin
                    credit_d = credit_q - WW'(1);
                end
            end
            default: ;
        endcase
        if (load) begin
            state_d      = GRANT;
            owner_d      = win;
            credit_d     = win_w;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            gv_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= IW'(N - 1);
            credit_q <= '0;
            grant_q  <= '0;
            gv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            gv_q     <= gv_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign grant_idx   = owner_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed and randomized bench for weighted_rr_arbiter with a
// tenure-level reference model.
module tb_weighted_rr_arbiter;

    localparam int N  = 4;
    localparam int WW = 3;
    localparam int IW = $clog2(N);

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            ack;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    int tests;
    int fails;

    int m_own;
    int m_cred;
    int m_last;
    int m_idx;

    int pat[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};

    weighted_rr_arbiter #(.N(N), .WW(WW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .weight     (weight),
        .ack        (ack),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wt(int i);
        return int'(weight[i*WW +: WW]);
    endfunction

    // First eligible requester strictly after 'from', wrapping; -1 if none.
    function automatic int search(int from);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (req[c] && wt(c) != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_cred = 0;
        m_last = N - 1;
        m_idx  = 0;
    endtask

    task automatic take(int w);
        m_own  = w;
        m_cred = wt(w);
        m_idx  = w;
    endtask

    task automatic model_step();
        int w;
        if (m_own < 0) begin
            w = search(m_last);
            if (w >= 0) take(w);
        end else if (!req[m_own] || (ack && m_cred == 1)) begin
            m_last = m_own;
            w = search(m_last);
            if (w >= 0) take(w);
            else m_own = -1;
        end else if (ack) begin
            m_cred = m_cred - 1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        chk("grant_valid", 32'(grant_valid), 32'(m_own >= 0));
        chk("grant_idx", 32'(grant_idx), 32'(m_idx));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        ack  = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rstn   = 1'b0;
        req    = '0;
        ack    = 1'b0;
        weight = '0;
        model_reset();

        // First grant after reset
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
        req    = 4'b0010;
        cycle();
        chk("first_grant", 32'(grant), 32'h2);
        chk("first_idx", 32'(grant_idx), 32'd1);

        // Weighted rotation, 10-cycle period
        do_reset();
        weight = {3'd4, 3'd3, 3'd2, 3'd1};
        req    = 4'b1111;
        ack    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [N-1:0] e;
            cycle();
            e = '0;
            e[pat[k%10]] = 1'b1;
            chk("wrr_pattern", 32'(grant), 32'(e));
        end

        // Masking
        do_reset();
        weight = {3'd1, 3'd0, 3'd1, 3'd2};
        req    = 4'b0101;
        ack    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("mask_only0", 32'(grant), 32'h1);
        end
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("mask_idle", 32'(grant_valid), 32'd0);
        end

        // Early release with ack in the release cycle
        do_reset();
        weight = {3'd1, 3'd3, 3'd1, 3'd1};
        req    = 4'b1100;
        cycle();
        chk("early_own2", 32'(grant), 32'h4);
        ack = 1'b1;
        cycle();
        req = 4'b1000;
        cycle();
        chk("early_rel", 32'(grant), 32'h8);
        ack = 1'b0;
        cycle();

        // Stall
        do_reset();
        weight = {3'd1, 3'd1, 3'd2, 3'd1};
        req    = 4'b0110;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_hold", 32'(grant), 32'h2);
        end
        ack = 1'b1;
        cycle();
        chk("stall_ack1", 32'(grant), 32'h2);
        cycle();
        chk("stall_rot", 32'(grant), 32'h4);

        // Asynchronous reset mid-grant
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
        req    = 4'b1000;
        ack    = 1'b0;
        cycle();
        chk("pre_rst", 32'(grant), 32'h8);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("async_clr", 32'(grant), 32'h0);
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        req  = 4'b1010;
        cycle();
        chk("restart0", 32'(grant), 32'h2);

        // Randomized traffic
        do_reset();
        weight = 12'($urandom);
        for (int k = 0; k < 600; k++) begin
            req = N'($urandom);
            if ($urandom_range(0, 3) != 0) req = req | grant;
            ack = 1'($urandom);
            if ($urandom_range(0, 7) == 0) weight = 12'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
